// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ADD/SUB/AND/OR plus an optional DATA_W-cycle shift-add multiplier.
// Optional feature macro: SEQ_ALU_MUL_EN (enables the MUL state, counter and multiplier datapath).
module seq_alu #(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [2:0]        ALUCtrl_i,
   input  logic [DATA_W-1:0] data1_i,
   input  logic [DATA_W-1:0] data2_i,
   output logic [DATA_W-1:0] data_o,
   output logic              Zero_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;

   // Returns {err, result}; any code without a single-cycle meaning is illegal.
   function automatic logic [DATA_W:0] alu_op(input logic [2:0]        op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
      case (op)
         OP_ADD:  return {1'b0, a + b};
         OP_SUB:  return {1'b0, a - b};
         OP_AND:  return {1'b0, a & b};
         OP_OR:   return {1'b0, a | b};
         default: return {1'b1, {DATA_W{1'b0}}};
      endcase
   endfunction

   logic              load_res;
   logic              err_d;
   logic [DATA_W-1:0] res_d;

`ifdef SEQ_ALU_MUL_EN
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] mcand, mplier, acc, acc_nxt;
   logic              mul_start;

   assign mul_start = (state == S_IDLE) && start_i && (ALUCtrl_i == OP_MUL);
   assign acc_nxt   = acc + (mplier[0] ? mcand : {DATA_W{1'b0}});
   assign busy_o    = (state == S_MUL);

   always_comb begin
      state_nxt = state;
      load_res  = 1'b0;
      err_d     = 1'b0;
      res_d     = '0;
      case (state)
         S_IDLE: begin
            if (start_i) begin
               if (ALUCtrl_i == OP_MUL) begin
                  state_nxt = S_MUL;
               end else begin
                  load_res       = 1'b1;
                  {err_d, res_d} = alu_op(ALUCtrl_i, data1_i, data2_i);
               end
            end
         end
         S_MUL: begin
            if (cnt == CNT_LAST) begin
               state_nxt = S_IDLE;
               load_res  = 1'b1;
               res_d     = acc_nxt;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (mul_start)
            cnt <= '0;
         else if (state == S_MUL)
            cnt <= cnt + 1'b1;
      end
   end

   // Multiplier datapath: operands latched at start so later input changes cannot leak in.
   always_ff @(posedge clk_i) begin
      if (mul_start) begin
         mcand  <= data1_i;
         mplier <= data2_i;
         acc    <= '0;
      end else if (state == S_MUL) begin
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         acc    <= acc_nxt;
      end
   end
`else
   assign busy_o = 1'b0;

   always_comb begin
      load_res       = start_i;
      {err_d, res_d} = alu_op(ALUCtrl_i, data1_i, data2_i);
   end
`endif

   // Result registers: written only on completion and held otherwise.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         data_o <= '0;
         Zero_o <= 1'b0;
         done_o <= 1'b0;
         err_o  <= 1'b0;
      end else begin
         done_o <= load_res;
         err_o  <= load_res & err_d;
         if (load_res) begin
            data_o <= res_d;
            Zero_o <= (res_d == '0);
         end
      end
   end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start_i, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 The block SHALL have port ALUCtrl_i, input, 3 bits: operation code, where 001 ADD, 010 SUB, 011 AND, 100 OR, 101 MUL, and 000/110/111 are illegal.
REQ-006 The block SHALL have ports data1_i and data2_i, input, DATA_W bits each: operands, sampled with start_i.
REQ-007 The block SHALL have port data_o, output, DATA_W bits: registered result, held until the next completion.
REQ-008 The block SHALL have port Zero_o, output, 1 bit: registered flag equal to (data_o == 0), updated together with data_o.
REQ-009 The block SHALL have port busy_o, output, 1 bit: high while a multi-cycle operation is in progress.
REQ-010 The block SHALL have port done_o, output, 1 bit: one-cycle pulse marking that data_o and Zero_o were just updated.
REQ-011 The block SHALL have port err_o, output, 1 bit: one-cycle pulse coincident with done_o for an illegal ALUCtrl_i.

Function
REQ-012 The block SHALL implement a state machine with states IDLE and MUL.
REQ-013 In IDLE, start_i=1 with a non-MUL code SHALL register the result at that edge, giving done_o=1 in the next cycle (latency 1); the state SHALL remain IDLE.
REQ-014 ADD and SUB SHALL be modulo 2^DATA_W with no carry or overflow output; AND and OR SHALL be bitwise.
REQ-015 In IDLE, start_i=1 with MUL SHALL latch both operands, clear the iteration counter and enter MUL.
REQ-016 In MUL, the block SHALL perform one shift-add iteration per cycle for exactly DATA_W cycles, producing the low DATA_W bits of the product (unsigned; identical to the signed low half).
REQ-017 At the edge ending iteration DATA_W-1, the block SHALL write data_o and Zero_o and return to IDLE; done_o SHALL be high in the following cycle. For DATA_W=32, a start in cycle N SHALL give done_o in N+33.
REQ-018 busy_o SHALL equal (state == MUL): high for exactly DATA_W cycles per MUL, low otherwise.
REQ-019 start_i SHALL be ignored while busy_o=1, and operand or ALUCtrl_i changes during MUL SHALL NOT affect the result.
REQ-020 In the cycle done_o=1, the state SHALL be IDLE, so a start_i in that cycle SHALL be accepted; back-to-back single-cycle operations SHALL sustain one result per cycle.
REQ-021 An illegal code SHALL complete with latency 1, with data_o=0, Zero_o=1 and err_o=1.
REQ-022 done_o and err_o SHALL be low in every cycle without a completion.

Reset
REQ-023 rst_i=0 SHALL immediately force state=IDLE, counter=0, data_o=0, Zero_o=0, busy_o=0, done_o=0 and err_o=0, independent of clk_i.
REQ-024 Reset asserted mid-MUL SHALL abort the operation with no done_o pulse afterwards; the first start_i after rst_i rises SHALL be accepted normally.

Configuration
REQ-025 With macro SEQ_ALU_MUL_EN defined, MUL SHALL behave as in REQ-015 to REQ-017.
REQ-026 Without SEQ_ALU_MUL_EN, code 101 SHALL be treated as illegal (REQ-021), the MUL state, counter and multiplier datapath SHALL be absent, and busy_o SHALL be tied to 0.

Verification
REQ-027 ADD 0x7FFFFFFF + 0x00000001 -> data_o=0x80000000, Zero_o=0, done_o one cycle after start; SUB 5-5 -> data_o=0, Zero_o=1.
REQ-028 AND 0xF0F0F0F0 with 0xFF00FF00 -> 0xF000F000; OR of the same operands -> 0xFFF0FFF0; issued back-to-back -> done_o high in two consecutive cycles.
REQ-029 MUL_EN defined, MUL 0x00010000 x 0x00010001 -> data_o=0x00010000 at N+33; busy_o high for cycles N+1..N+32; a start_i ADD issued at N+5 produces no response.
REQ-030 MUL 0xFFFFFFFF x 0xFFFFFFFF -> data_o=0x00000001; operands changed during busy_o -> result unchanged.
REQ-031 rst_i pulsed low at N+10 of a MUL -> all outputs 0 immediately and no done_o; a following ALUCtrl_i=110 -> data_o=0, Zero_o=1, err_o=1 with done_o.
REQ-032 MUL_EN undefined, ALUCtrl_i=101 with 3x4 -> latency 1, data_o=0, err_o=1, busy_o never high.
